square_reconstruct: RTL
=======================

# square_reconstruct

Sequential inverse of the floor-square-root unit. Given a root `r` and remainder `e`, it reconstructs `num = r*r + e` with a shift-add multiplier that processes one root bit per cycle. It also flags remainders that are not canonical, meaning `e > 2*r`. It sits on the checking/decode side of the square-root path and uses valid/ready handshakes on both ends.

## Interface
Parameters:
- `RW`, default 5: root width. The number width is `NW = 2*RW` (10), and the remainder width is `RW+1` (6).

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `in_valid`  in  1  input operands are valid
- `in_ready`  out  1  block can accept operands
- `root`  in  RW  root `r`
- `rem`  in  RW+1  remainder `e`
- `out_valid`  out  1  result is valid
- `out_ready`  in  1  downstream accepts the result
- `num`  out  NW  result `r*r + e`, taken modulo `2^NW`
- `rem_err`  out  1  high when `e > 2*r` (non-canonical remainder)

## Operation
- FSM states are IDLE, MUL, ADD and DONE.
- **IDLE**
  - `in_ready` = 1.
  - On `in_valid && in_ready`: latch `root` and `rem`, clear the accumulator, clear the bit index, and go to MUL.
- **MUL** runs for exactly RW cycles. Bit index `i` goes from 0 to RW-1, LSB first.
  - If `root[i]` is set: `acc += root << i`, computed at NW-bit width.
  - After `i = RW-1`, go to ADD.
- **ADD** runs for one cycle.
  - `acc = (acc + rem) mod 2^NW`.
  - `rem_err = (rem > {root,1'b0})`. The comparison is done at RW+1 bits.
  - Go to DONE.
- **DONE**
  - `out_valid` = 1.
  - On `out_ready`, go to IDLE. The next operand is not accepted in the same cycle.
- **Arithmetic**
  - With a canonical remainder, `r*r + e <= (r+1)^2 - 1 < 2^NW`, so no wrap occurs.
  - The only wrapping case is `r = 2^RW-1`, `e = 2^(RW+1)-1`. It yields `num = 0` with `rem_err = 1`.
- **Output stability**: `num` and `rem_err` are driven from registers. They hold stable while `out_valid && !out_ready`.
- **Inputs outside IDLE**: `root` and `rem` are ignored outside IDLE. Upstream holds them while `in_valid && !in_ready`.

## Timing
- **Reset values**: `in_ready` = 0 during reset, then 1 in the first cycle after reset. `out_valid` = 0, `num` = 0, `rem_err` = 0, state = IDLE.
- **Latency**: operands are accepted at edge T. `out_valid` rises after edge T+RW+1, i.e. after RW MUL cycles plus 1 ADD cycle.
- **Throughput**: at most one operation per RW+3 cycles, assuming `out_ready` is held high. This is 8 cycles at RW = 5.
- **Reset mid-operation**: `rst` asserted in any state aborts the transaction. The state returns to IDLE on that edge, outputs return to their reset values, and no `out_valid` is produced.
- **In/out overlap**: `in_ready` and `out_valid` are never high in the same cycle.
- **Input errors**: there is no error path for inputs. `rem_err` is informational only and is valid only while `out_valid` = 1.

## Structure
- **Shared package `sqrt_pkg`** holds:
  - the `RW` default;
  - the derived `NW`;
  - the state enum `sq_state_t` (IDLE, MUL, ADD, DONE).
  - The square-root unit reuses the same width constants.
- **Single module**: the shift-add datapath is small, so no sub-module is needed. The FSM and datapath live in one module.

## Test plan
- `root=0`, `rem=0` -> `num=0`, `rem_err=0`. `out_valid` rises exactly 6 cycles after the accept edge.
- `root=12`, `rem=5` -> `num=149`, `rem_err=0`. Then `root=31`, `rem=62` -> `num=1023`, `rem_err=0`.
- `root=3`, `rem=7` -> `num=16`, `rem_err=1`. Also `root=31`, `rem=63` -> `num=0`, `rem_err=1` (the wrap case).
- Backpressure: hold `out_ready=0` for 10 cycles after `out_valid` -> `num`/`rem_err` stay stable and `in_ready` stays 0. Release it -> handshake completes and `in_ready`=1 on the next cycle.
- Assert `rst` during the MUL cycle for `i=2` -> the next cycle is IDLE with all outputs 0 and no `out_valid`. The following operation `root=7`, `rem=0` -> `num=49`.
- Back-to-back: `in_valid` high continuously with `out_ready` high, over the sequence r = 0..31 with `e = r` -> each `num = r*r + r`, `rem_err=0`, with an 8-cycle spacing between accepts.

Source files
------------

// File: rtl/sqrt_pkg.sv
// sqrt_pkg: width constants and FSM state type shared by the floor-square-root
// unit and its inverse, square_reconstruct.
//   RW_DEF     default root width
//   NW_DEF     derived number width (2*RW_DEF)
//   sq_state_t reconstruct FSM states
package sqrt_pkg;
    localparam int RW_DEF = 5;
    localparam int NW_DEF = 2 * RW_DEF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        ADD  = 2'd2,
        DONE = 2'd3
    } sq_state_t;
endpackage

// File: rtl/square_reconstruct_if.sv
// square_reconstruct_if: valid/ready operand and result bus of square_reconstruct.
//   in_valid/in_ready   operand handshake (root, rem)
//   out_valid/out_ready result handshake (num, rem_err)
// master = upstream/downstream side, slave = the reconstruct block.
interface square_reconstruct_if #(
    parameter int RW = sqrt_pkg::RW_DEF
);
    logic              in_valid;
    logic              in_ready;
    logic [RW-1:0]     root;
    logic [RW:0]       rem;
    logic              out_valid;
    logic              out_ready;
    logic [2*RW-1:0]   num;
    logic              rem_err;

    modport master (
        output in_valid, root, rem, out_ready,
        input  in_ready, out_valid, num, rem_err
    );

    modport slave (
        input  in_valid, root, rem, out_ready,
        output in_ready, out_valid, num, rem_err
    );
endinterface

// File: rtl/square_reconstruct.sv
// square_reconstruct: sequential inverse of the floor square root.
// Rebuilds num = r*r + e (mod 2^NW) with a shift-add multiplier that consumes
// one root bit per cycle (LSB first), then adds the remainder. Flags
// non-canonical remainders (e > 2*r) on rem_err.
// Ports:
//   clk  clock
//   rst  synchronous, active-high reset; aborts any transaction
//   bus  square_reconstruct_if.slave (root/rem in, num/rem_err out, valid/ready)
module square_reconstruct
    import sqrt_pkg::*;
#(
    parameter int RW = RW_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    square_reconstruct_if.slave  bus
);
    localparam int NW = 2 * RW;
    localparam int IW = (RW > 1) ? $clog2(RW) : 1;

    sq_state_t       state_q, state_d;
    logic [RW-1:0]   root_q;
    logic [RW:0]     rem_q;
    logic [NW-1:0]   acc_q;
    logic [IW-1:0]   idx_q;
    logic            rem_err_q;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Handshake outputs are masked during reset so nothing is offered or
    // accepted in a cycle that is about to be aborted.
    always_comb begin
        state_d       = state_q;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                bus.in_ready = !rst;
                if (bus.in_valid) state_d = MUL;
            end
            MUL: begin
                if (idx_q == IW'(RW - 1)) state_d = ADD;
            end
            ADD: begin
                state_d = DONE;
            end
            DONE: begin
                bus.out_valid = !rst;
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            root_q    <= '0;
            rem_q     <= '0;
            acc_q     <= '0;
            idx_q     <= '0;
            rem_err_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        root_q    <= bus.root;
                        rem_q     <= bus.rem;
                        acc_q     <= '0;
                        idx_q     <= '0;
                        rem_err_q <= 1'b0;
                    end
                end
                MUL: begin
                    // Partial product for bit i is root shifted left by i.
                    if (root_q[idx_q]) acc_q <= acc_q + (NW'(root_q) << idx_q);
                    idx_q <= idx_q + 1'b1;
                end
                ADD: begin
                    acc_q     <= acc_q + NW'(rem_q);
                    rem_err_q <= (rem_q > {root_q, 1'b0});
                end
                default: ;
            endcase
        end
    end

    // Result is the accumulator itself; it only moves in MUL/ADD, so it is
    // stable for as long as DONE is held by backpressure.
    assign bus.num     = acc_q;
    assign bus.rem_err = rem_err_q;
endmodule
